// File: rtl/align_data_fifo.sv
// rtl/align_data_fifo.sv - packs narrow words into wide frames and queues them in a first-word-fall-through FIFO
module align_data_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 0
) (
    input  logic                                Clk,
    input  logic                                Reset_b,
    input  logic [$clog2(MAX_WORDS):0]          WordsPerFrame,
    input  logic                                Write,
    output logic                                Full,
    input  logic [DATA_WIDTH-1:0]               DataWrite,
    input  logic                                EofWrite,
    input  logic                                Flush,
    output logic                                Empty,
    input  logic                                Read,
    output logic [MAX_WORDS*DATA_WIDTH-1:0]     DataRead,
    output logic [MAX_WORDS-1:0]                WordEnableRead,
    output logic                                EofRead,
    output logic [$clog2(FIFO_DEPTH):0]         Level
);

    localparam int CW     = $clog2(MAX_WORDS);
    localparam int LW     = CW + 1;
    localparam int FW     = MAX_WORDS * DATA_WIDTH;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int TO_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int TW     = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;

    // accumulator state
    logic [FW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        to_cnt_q, to_cnt_d;

    // output FIFO state
    logic [FW-1:0]        mem_data_q [FIFO_DEPTH];
    logic [MAX_WORDS-1:0] mem_en_q   [FIFO_DEPTH];
    logic                 mem_eof_q  [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          level_q, level_d;

    logic                 fifo_full, fifo_empty;
    logic                 accept, pop, push, close_acc, to_fire;
    logic [LW-1:0]        eff_len, cnt_ext, fill;
    logic [FW-1:0]        frame_data;
    logic [MAX_WORDS-1:0] frame_en;
    logic                 frame_eof;

    assign fifo_full  = (level_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign accept     = Write & ~fifo_full;
    assign pop        = Read & ~fifo_empty;
    assign cnt_ext    = {1'b0, cnt_q};
    assign to_fire    = (TIMEOUT != 0) && (to_cnt_q == TW'(TO_MAX));

    // clamp the requested frame length into 1..MAX_WORDS
    always_comb begin
        eff_len = WordsPerFrame;
        if (WordsPerFrame == '0 || WordsPerFrame > LW'(MAX_WORDS)) begin
            eff_len = LW'(MAX_WORDS);
        end
    end

    // decide whether a frame closes this cycle; >= also covers a length shrunk below cnt
    always_comb begin
        close_acc = accept & (((cnt_ext + LW'(1)) >= eff_len) | EofWrite | Flush);
        push      = close_acc |
                    (~accept & ~fifo_full & (cnt_q != '0) & (Flush | to_fire));
        frame_eof = accept & EofWrite;
        fill      = cnt_ext + LW'(accept);
    end

    // frame image: accumulator with the incoming word merged at slot cnt, plus thermometer enable
    always_comb begin
        frame_data = acc_q;
        frame_en   = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (accept && cnt_q == CW'(i)) begin
                frame_data[i*DATA_WIDTH +: DATA_WIDTH] = DataWrite;
            end
            frame_en[i] = (LW'(i) < fill);
        end
    end

    // accumulator and idle-timeout next state
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        to_cnt_d = to_cnt_q;
        if (push) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = frame_data;
            cnt_d = cnt_q + CW'(1);
        end
        if (accept || push || cnt_q == '0 || TIMEOUT == 0) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TO_MAX)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // FIFO occupancy next state
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (PW+1)'(1);
            2'b01:   level_d = level_q - (PW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // accumulator registers
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            to_cnt_q <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // FIFO storage, pointers and level
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_en_q[i]   <= '0;
                mem_eof_q[i]  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= frame_data;
                mem_en_q[wr_ptr_q]   <= frame_en;
                mem_eof_q[wr_ptr_q]  <= frame_eof;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;
        end
    end

    // head of FIFO falls through; outputs are forced to zero while empty
    assign Full           = fifo_full | ~Reset_b;
    assign Empty          = fifo_empty;
    assign Level          = level_q;
    assign DataRead       = fifo_empty ? '0 : mem_data_q[rd_ptr_q];
    assign WordEnableRead = fifo_empty ? '0 : mem_en_q[rd_ptr_q];
    assign EofRead        = fifo_empty ? 1'b0 : mem_eof_q[rd_ptr_q];

endmodule

// File: tb/tb_align_data_fifo.sv
// tb/tb_align_data_fifo.sv - directed self-checking bench for align_data_fifo
module tb_align_data_fifo;

    localparam int DW = 32;
    localparam int MW = 8;
    localparam int FD = 4;
    localparam int TO = 16;

    logic            Clk = 1'b0;
    logic            Reset_b;
    logic [3:0]      WordsPerFrame;
    logic            Write;
    logic            Full;
    logic [DW-1:0]   DataWrite;
    logic            EofWrite;
    logic            Flush;
    logic            Empty;
    logic            Read;
    logic [MW*DW-1:0] DataRead;
    logic [MW-1:0]   WordEnableRead;
    logic            EofRead;
    logic [2:0]      Level;

    int checks   = 0;
    int failures = 0;

    align_data_fifo #(
        .DATA_WIDTH (DW),
        .MAX_WORDS  (MW),
        .FIFO_DEPTH (FD),
        .TIMEOUT    (TO)
    ) dut (
        .Clk            (Clk),
        .Reset_b        (Reset_b),
        .WordsPerFrame  (WordsPerFrame),
        .Write          (Write),
        .Full           (Full),
        .DataWrite      (DataWrite),
        .EofWrite       (EofWrite),
        .Flush          (Flush),
        .Empty          (Empty),
        .Read           (Read),
        .DataRead       (DataRead),
        .WordEnableRead (WordEnableRead),
        .EofRead        (EofRead),
        .Level          (Level)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_frame(input logic [31:0] first, input int n);
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < n; i++) f[i*32 +: 32] = first + 32'(i);
        return f;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d, input logic eof);
        Write     = 1'b1;
        DataWrite = d;
        EofWrite  = eof;
        tick();
        Write     = 1'b0;
        EofWrite  = 1'b0;
    endtask

    task automatic write_run(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) write_word(first + 32'(i), 1'b0);
    endtask

    task automatic do_read();
        Read = 1'b1;
        tick();
        Read = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [255:0] data,
                              input logic [7:0] en, input logic eof);
        check({tag, "_data"}, DataRead, data);
        check({tag, "_en"},   WordEnableRead, en);
        check({tag, "_eof"},  EofRead, eof);
    endtask

    initial begin
        Reset_b = 1'b0; WordsPerFrame = 4'd4; Write = 1'b0; DataWrite = '0;
        EofWrite = 1'b0; Flush = 1'b0; Read = 1'b0;
        tick();
        check("rst_full_low", Full, 1'b1);
        tick();
        Reset_b = 1'b1;
        #1;
        check("rst_full",  Full, 1'b0);
        check("rst_empty", Empty, 1'b1);
        check("rst_level", Level, 3'd0);
        check_head("rst_head", '0, 8'h00, 1'b0);

        // len 4: eight words make two frames
        WordsPerFrame = 4'd4;
        write_run(32'h1, 8);
        check("t1_level", Level, 3'd2);
        check_head("t1_f0", make_frame(32'h1, 4), 8'h0F, 1'b0);
        do_read();
        check_head("t1_f1", make_frame(32'h5, 4), 8'h0F, 1'b0);
        do_read();
        check("t1_empty", Empty, 1'b1);

        // EOF closes a short frame
        WordsPerFrame = 4'd8;
        write_word(32'hA, 1'b0);
        write_word(32'hB, 1'b0);
        check("t2_empty_before", Empty, 1'b1);
        write_word(32'hC, 1'b1);
        check("t2_empty_after", Empty, 1'b0);
        check_head("t2_f", make_frame(32'hA, 3), 8'h07, 1'b1);
        do_read();

        // idle timeout closes a partial frame after exactly 16 idle cycles
        write_run(32'h11, 2);
        for (int i = 0; i < 15; i++) tick();
        check("t3_empty_15", Empty, 1'b1);
        tick();
        check("t3_level_16", Level, 3'd1);
        check_head("t3_f", make_frame(32'h11, 2), 8'h03, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        check("t3_no_extra", Level, 3'd1);
        do_read();
        Flush = 1'b1; tick(); Flush = 1'b0; tick();
        check("t3_flush_cnt0", Empty, 1'b1);
        write_word(32'h33, 1'b0);
        Flush = 1'b1; tick(); Flush = 1'b0;
        check_head("t3_flush_partial", make_frame(32'h33, 1), 8'h01, 1'b0);
        do_read();

        // back-pressure with len 2
        WordsPerFrame = 4'd2;
        write_run(32'h101, 8);
        check("t4_level_full", Level, 3'd4);
        check("t4_full", Full, 1'b1);
        Write = 1'b1; DataWrite = 32'h109;
        tick(); tick();
        check("t4_held_level", Level, 3'd4);
        Read = 1'b1; tick(); Read = 1'b0;
        check("t4_full_drop", Full, 1'b0);
        check("t4_level_3", Level, 3'd3);
        tick();
        DataWrite = 32'h10A; Read = 1'b1;
        tick();
        Read = 1'b0; Write = 1'b0;
        check("t4_pushpop_level", Level, 3'd3);
        write_run(32'h10B, 2);
        check("t4_refull", Full, 1'b1);
        check_head("t4_f2", make_frame(32'h105, 2), 8'h03, 1'b0);
        do_read();
        check_head("t4_f3", make_frame(32'h107, 2), 8'h03, 1'b0);
        do_read();
        check_head("t4_f4", make_frame(32'h109, 2), 8'h03, 1'b0);
        do_read();
        check_head("t4_f5", make_frame(32'h10B, 2), 8'h03, 1'b0);
        do_read();
        check("t4_drained", Empty, 1'b1);

        // reset mid-frame discards FIFO contents and partial frame
        WordsPerFrame = 4'd8;
        write_word(32'h40, 1'b1);
        write_run(32'h50, 5);
        Reset_b = 1'b0;
        #1;
        check("t5_full_in_rst", Full, 1'b1);
        check("t5_empty_in_rst", Empty, 1'b1);
        check("t5_level_in_rst", Level, 3'd0);
        tick();
        Reset_b = 1'b1;
        #1;
        check("t5_full_after", Full, 1'b0);
        write_run(32'h0, 8);
        check("t5_level", Level, 3'd1);
        check_head("t5_f", make_frame(32'h0, 8), 8'hFF, 1'b0);
        do_read();

        // out-of-range lengths clamp to MAX_WORDS
        WordsPerFrame = 4'd0;
        write_run(32'h60, 7);
        check("t6_len0_partial", Empty, 1'b1);
        write_word(32'h67, 1'b0);
        check_head("t6_len0", make_frame(32'h60, 8), 8'hFF, 1'b0);
        do_read();
        WordsPerFrame = 4'd12;
        write_run(32'h70, 7);
        check("t6_len12_partial", Empty, 1'b1);
        write_word(32'h77, 1'b0);
        check_head("t6_len12", make_frame(32'h70, 8), 8'hFF, 1'b0);
        do_read();

        // shrinking the length below cnt closes on the next accept
        WordsPerFrame = 4'd8;
        write_run(32'h80, 3);
        WordsPerFrame = 4'd2;
        write_word(32'h83, 1'b0);
        check_head("t7_shrink", make_frame(32'h80, 4), 8'h0F, 1'b0);
        do_read();
        check("t7_empty", Empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
